// File: rtl/mipi_prbs_pkg.sv
// Shared PRBS definitions for the MIPI payload checker and the parametrised generator.
package mipi_prbs_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } prbsState_t;

  typedef struct packed {
    int tapA;
    int tapB;
  } prbsTaps_t;

  localparam logic [7:0] SYM_ONE  = 8'hAA;
  localparam logic [7:0] SYM_ZERO = 8'h55;

  // tapA is always the order itself; tapB is the inner tap of x^order + x^tapB + 1.
  function automatic prbsTaps_t prbsTaps(input int order);
    prbsTaps_t t;
    t.tapA = order;
    case (order)
      7:       t.tapB = 6;
      9:       t.tapB = 5;
      15:      t.tapB = 14;
      23:      t.tapB = 18;
      31:      t.tapB = 28;
      default: t.tapB = order - 1;
    endcase
    return t;
  endfunction

  function automatic int fillWords(input int order, input int lanes);
    return (order + lanes - 1) / lanes;
  endfunction

endpackage

// File: rtl/prbs_par_step.sv
// Combinational LANES-step advance of an ORDER-bit Fibonacci LFSR history.
// histIn[0] is the newest bit; useRx selects received bits over predicted bits as feed-back.
module prbs_par_step #(
  parameter int ORDER = 9,
  parameter int LANES = 8,
  parameter int TAP_A = 9,
  parameter int TAP_B = 5
) (
  input  logic [ORDER-1:0] histIn,
  input  logic [LANES-1:0] rxBits,
  input  logic             useRx,
  output logic [LANES-1:0] pred,
  output logic [ORDER-1:0] histOut
);

  logic [ORDER-1:0] h;
  logic             p;

  // Oldest bit sits in the top lane, so walk lanes from LANES-1 down to 0.
  always_comb begin
    h    = histIn;
    p    = 1'b0;
    pred = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      p       = h[TAP_A-1] ^ h[TAP_B-1];
      pred[i] = p;
      h       = {h[ORDER-2:0], (useRx ? rxBits[i] : p)};
    end
    histOut = h;
  end

endmodule

// File: rtl/mipi_prbs_checker_nb.sv
// N-byte MIPI payload PRBS checker: byte decode, self-sync, lock tracking and error reporting.
// Error/right counters exist only when MIPI_PRBS_ERRCNT_EN is defined; otherwise ErrCnt/Right are 0.
module mipi_prbs_checker_nb
  import mipi_prbs_pkg::*;
#(
  parameter int LANES       = 8,
  parameter int PRBS_ORDER  = 9,
  parameter int LOCK_CNT    = 16,
  parameter int UNLOCK_ERR  = 4,
  parameter int ERR_CNT_W   = 16,
  parameter int RIGHT_CNT_W = 20
) (
  input  logic                 SysClk,
  input  logic                 Reset_N,
  input  logic                 RxDValid,
  input  logic [LANES*8-1:0]   RxData,
  input  logic                 ClrCnt,
  output logic                 Locked,
  output logic [LANES-1:0]     ByteErr,
  output logic [LANES-1:0]     BitErr,
  output logic [ERR_CNT_W-1:0] ErrCnt,
  output logic                 Right
);

  localparam prbsTaps_t TAPS       = prbsTaps(PRBS_ORDER);
  localparam int        FILL       = fillWords(PRBS_ORDER, LANES);
  localparam logic [5:0] FILL_LAST   = 6'(FILL - 1);
  localparam logic [7:0] LOCK_LAST   = 8'(LOCK_CNT - 1);
  localparam logic [3:0] UNLOCK_LAST = 4'(UNLOCK_ERR - 1);

  prbsState_t            state, stateNext;
  logic [PRBS_ORDER-1:0] hist, histNext;
  logic [LANES-1:0]      rxBit, sym, pred, bitErrNext;
  logic                  anySym, wordClean, useRx;
  logic [5:0]            fillCnt;
  logic [7:0]            matchCnt;
  logic [3:0]            errRun;

  always_comb begin
    rxBit = '0;
    sym   = '0;
    for (int k = 0; k < LANES; k++) begin
      rxBit[k] = RxData[8*k+7];
      sym[k]   = (RxData[8*k +: 8] != SYM_ONE) && (RxData[8*k +: 8] != SYM_ZERO);
    end
  end

  assign anySym     = |sym;
  assign bitErrNext = pred ^ rxBit;
  assign wordClean  = (bitErrNext == '0) && !anySym;

  prbs_par_step #(
    .ORDER (PRBS_ORDER),
    .LANES (LANES),
    .TAP_A (TAPS.tapA),
    .TAP_B (TAPS.tapB)
  ) uStep (
    .histIn  (hist),
    .rxBits  (rxBit),
    .useRx   (useRx),
    .pred    (pred),
    .histOut (histNext)
  );

  // state  | meaning
  // HUNT   | filling history from received bits, waiting for FILL clean words
  // VERIFY | history self-syncs on received bits, counting clean words to LOCK_CNT
  // LOCKED | history free-runs on predictions, UNLOCK_ERR dirty words in a row drop lock
  always_ff @(posedge SysClk or negedge Reset_N) begin
    if (!Reset_N) state <= HUNT;
    else          state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (RxDValid) begin
      case (state)
        HUNT:    if (!anySym && fillCnt == FILL_LAST) stateNext = VERIFY;
        VERIFY:  if (!wordClean) stateNext = HUNT;
                 else if (matchCnt == LOCK_LAST) stateNext = LOCKED;
        LOCKED:  if (!wordClean && errRun == UNLOCK_LAST) stateNext = HUNT;
        default: stateNext = HUNT;
      endcase
    end
  end

  always_comb begin
    Locked = (state == LOCKED);
    useRx  = (state != LOCKED);
  end

  always_ff @(posedge SysClk or negedge Reset_N) begin
    if (!Reset_N) begin
      hist     <= '0;
      fillCnt  <= '0;
      matchCnt <= '0;
      errRun   <= '0;
    end else if (RxDValid) begin
      hist <= histNext;
      case (state)
        HUNT: begin
          fillCnt  <= (anySym || fillCnt == FILL_LAST) ? 6'd0 : fillCnt + 6'd1;
          matchCnt <= '0;
          errRun   <= '0;
        end
        VERIFY: begin
          fillCnt  <= '0;
          matchCnt <= wordClean ? matchCnt + 8'd1 : 8'd0;
          errRun   <= '0;
        end
        LOCKED: begin
          fillCnt <= '0;
          errRun  <= (wordClean || errRun == UNLOCK_LAST) ? 4'd0 : errRun + 4'd1;
        end
        default: begin
          fillCnt  <= '0;
          matchCnt <= '0;
          errRun   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge SysClk or negedge Reset_N) begin
    if (!Reset_N) begin
      ByteErr <= '0;
      BitErr  <= '0;
    end else begin
      ByteErr <= RxDValid ? sym : '0;
      BitErr  <= (RxDValid && state == LOCKED) ? bitErrNext : '0;
    end
  end

`ifdef MIPI_PRBS_ERRCNT_EN
  localparam int SUM_W = ERR_CNT_W + 7;

  logic [ERR_CNT_W-1:0]   errCnt;
  logic [RIGHT_CNT_W-1:0] rightCnt;
  logic [5:0]             errInc;
  logic [SUM_W-1:0]       errSum;

  always_comb begin
    errInc = '0;
    for (int k = 0; k < LANES; k++) begin
      errInc = errInc + {5'd0, (bitErrNext[k] | sym[k])};
    end
    errSum = SUM_W'(errCnt) + SUM_W'(errInc);
  end

  always_ff @(posedge SysClk or negedge Reset_N) begin
    if (!Reset_N) begin
      errCnt <= '0;
    end else if (ClrCnt) begin
      errCnt <= '0;
    end else if (RxDValid && state == LOCKED) begin
      errCnt <= (errSum > SUM_W'({ERR_CNT_W{1'b1}})) ? '1 : errSum[ERR_CNT_W-1:0];
    end
  end

  always_ff @(posedge SysClk or negedge Reset_N) begin
    if (!Reset_N) begin
      rightCnt <= '0;
    end else if (ClrCnt || state != LOCKED) begin
      rightCnt <= '0;
    end else if (RxDValid) begin
      if (!wordClean)     rightCnt <= '0;
      else if (!(&rightCnt)) rightCnt <= rightCnt + 1'b1;
    end
  end

  assign ErrCnt = errCnt;
  assign Right  = &rightCnt;
`else
  localparam int unusedRightW = RIGHT_CNT_W;
  logic unusedClr;
  assign unusedClr = ClrCnt;
  assign ErrCnt    = '0;
  assign Right     = 1'b0;
`endif

endmodule

// File: tb/tb_mipi_prbs_checker_nb.sv
// Directed bench for mipi_prbs_checker_nb: vector table plus hand-written reset/valid/random sequences.
module tb_mipi_prbs_checker_nb;

  localparam int LANES = 8;

`ifdef MIPI_PRBS_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct {
    logic        valid;
    logic        clr;
    logic [63:0] data;
    logic        expLocked;
    logic [7:0]  expByte;
    logic [7:0]  expBit;
    int          expErr;
    logic        expRightS;
  } vec_t;

  logic        SysClk = 1'b0;
  logic        Reset_N;
  logic        RxDValid;
  logic [63:0] RxData;
  logic        ClrCnt;
  logic        Locked, LockedS;
  logic [7:0]  ByteErr, BitErr, ByteErrS, BitErrS;
  logic [15:0] ErrCnt;
  logic [3:0]  ErrCntS;
  logic        Right, RightS;

  int checks   = 0;
  int failures = 0;

  logic prbsBit [0:2047];
  int   bitPos = 0;
  vec_t vecs[$];

  always #5 SysClk = ~SysClk;

  mipi_prbs_checker_nb #(
    .LANES(LANES), .PRBS_ORDER(9), .LOCK_CNT(16), .UNLOCK_ERR(4),
    .ERR_CNT_W(16), .RIGHT_CNT_W(20)
  ) dut (
    .SysClk(SysClk), .Reset_N(Reset_N), .RxDValid(RxDValid), .RxData(RxData),
    .ClrCnt(ClrCnt), .Locked(Locked), .ByteErr(ByteErr), .BitErr(BitErr),
    .ErrCnt(ErrCnt), .Right(Right)
  );

  mipi_prbs_checker_nb #(
    .LANES(LANES), .PRBS_ORDER(9), .LOCK_CNT(16), .UNLOCK_ERR(4),
    .ERR_CNT_W(4), .RIGHT_CNT_W(3)
  ) dutS (
    .SysClk(SysClk), .Reset_N(Reset_N), .RxDValid(RxDValid), .RxData(RxData),
    .ClrCnt(ClrCnt), .Locked(LockedS), .ByteErr(ByteErrS), .BitErr(BitErrS),
    .ErrCnt(ErrCntS), .Right(RightS)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Eight stream bits, oldest in bit 7 (byte LANES-1).
  task automatic nextBits(output logic [7:0] bits);
    for (int k = 7; k >= 0; k--) begin
      bits[k] = prbsBit[bitPos];
      bitPos++;
    end
  endtask

  function automatic logic [63:0] toWord(input logic [7:0] bits);
    logic [63:0] w;
    for (int k = 0; k < 8; k++) w[8*k +: 8] = bits[k] ? 8'hAA : 8'h55;
    return w;
  endfunction

  task automatic addVec(input logic valid, input logic clr, input logic [63:0] data,
                        input logic expLocked, input logic [7:0] expByte,
                        input logic [7:0] expBit, input int expErr, input logic expRightS);
    vec_t v;
    v.valid = valid; v.clr = clr; v.data = data; v.expLocked = expLocked;
    v.expByte = expByte; v.expBit = expBit; v.expErr = expErr; v.expRightS = expRightS;
    vecs.push_back(v);
  endtask

  task automatic checkResetValues(input string tag);
    check({tag, " locked"},  64'(Locked),  64'd0);
    check({tag, " byteErr"}, 64'(ByteErr), 64'd0);
    check({tag, " bitErr"},  64'(BitErr),  64'd0);
    check({tag, " errCnt"},  64'(ErrCnt),  64'd0);
    check({tag, " right"},   64'(Right),   64'd0);
    check({tag, " lockedS"}, 64'(LockedS), 64'd0);
  endtask

  initial begin
    logic [7:0]  b;
    logic [63:0] w;
    int          errTot;
    int          anomalies;

    for (int n = 0; n < 9; n++) prbsBit[n] = 1'b1;
    for (int n = 9; n < 2048; n++) prbsBit[n] = prbsBit[n-9] ^ prbsBit[n-5];

    // clean acquisition: 2 fill + 16 verify words
    for (int i = 0; i < 18; i++) begin
      nextBits(b); addVec(1, 0, toWord(b), (i == 17), 8'h00, 8'h00, 0, 0);
    end
    for (int i = 0; i < 3; i++) begin
      nextBits(b); addVec(1, 0, toWord(b), 1, 8'h00, 8'h00, 0, 0);
    end
    // symbol error on byte 3
    nextBits(b); w = toWord(b); w[31:24] = 8'h5A;
    addVec(1, 0, w, 1, 8'h08, (b[3] ? 8'h08 : 8'h00), 1, 0);
    nextBits(b); addVec(1, 0, toWord(b), 1, 8'h00, 8'h00, 1, 0);
    // idle cycle with garbage data holds everything
    addVec(0, 0, 64'h0123_4567_89AB_CDEF, 1, 8'h00, 8'h00, 1, 0);
    // single bit flip on byte 5, no echo afterwards
    nextBits(b); w = toWord(b); w[47:40] = b[5] ? 8'h55 : 8'hAA;
    addVec(1, 0, w, 1, 8'h00, 8'h20, 2, 0);
    for (int i = 0; i < 3; i++) begin
      nextBits(b); addVec(1, 0, toWord(b), 1, 8'h00, 8'h00, 2, 0);
    end
    // clear on a clean word, then clear colliding with an error word
    nextBits(b); addVec(1, 1, toWord(b), 1, 8'h00, 8'h00, 0, 0);
    nextBits(b); w = toWord(b); w[7:0] = b[0] ? 8'h55 : 8'hAA;
    addVec(1, 1, w, 1, 8'h00, 8'h01, 0, 0);
    // small instance saturates its 3-bit right counter after 7 clean words
    for (int i = 0; i < 8; i++) begin
      nextBits(b); addVec(1, 0, toWord(b), 1, 8'h00, 8'h00, 0, (i >= 6));
    end
    nextBits(b); w = toWord(b); w[23:16] = 8'h00;
    addVec(1, 0, w, 1, 8'h04, (b[2] ? 8'h04 : 8'h00), 1, 0);
    nextBits(b); addVec(1, 0, toWord(b), 1, 8'h00, 8'h00, 1, 0);
    // four all-zero words drop lock on the fourth
    errTot = 1;
    for (int i = 0; i < 4; i++) begin
      nextBits(b); errTot += 8;
      addVec(1, 0, 64'h0, (i < 3), 8'hFF, b, errTot, 0);
    end
    for (int i = 0; i < 18; i++) begin
      nextBits(b); addVec(1, 0, toWord(b), (i == 17), 8'h00, 8'h00, errTot, 0);
    end

    Reset_N = 1'b0; RxDValid = 1'b0; RxData = '0; ClrCnt = 1'b0;
    #12;
    checkResetValues("in-reset");
    #10 Reset_N = 1'b1;
    @(posedge SysClk); #1;
    checkResetValues("post-reset");

    for (int i = 0; i < vecs.size(); i++) begin
      RxDValid = vecs[i].valid; RxData = vecs[i].data; ClrCnt = vecs[i].clr;
      @(posedge SysClk); #1;
      check($sformatf("vec%0d locked", i),  64'(Locked),   64'(vecs[i].expLocked));
      check($sformatf("vec%0d lockedS", i), 64'(LockedS),  64'(vecs[i].expLocked));
      check($sformatf("vec%0d byteErr", i), 64'(ByteErr),  64'(vecs[i].expByte));
      check($sformatf("vec%0d bitErr", i),  64'(BitErr),   64'(vecs[i].expBit));
      check($sformatf("vec%0d bitErrS", i), 64'(BitErrS),  64'(vecs[i].expBit));
      check($sformatf("vec%0d byteErrS", i), 64'(ByteErrS), 64'(vecs[i].expByte));
      check($sformatf("vec%0d errCnt", i),  64'(ErrCnt),
            CNT_EN ? 64'(vecs[i].expErr) : 64'd0);
      check($sformatf("vec%0d errCntS", i), 64'(ErrCntS),
            CNT_EN ? 64'((vecs[i].expErr > 15) ? 15 : vecs[i].expErr) : 64'd0);
      check($sformatf("vec%0d right", i),   64'(Right),    64'd0);
      check($sformatf("vec%0d rightS", i),  64'(RightS),
            CNT_EN ? 64'(vecs[i].expRightS) : 64'd0);
    end
    RxDValid = 1'b0; ClrCnt = 1'b0;

    // asynchronous reset while locked clears everything at once
    #3 Reset_N = 1'b0;
    #1;
    checkResetValues("mid-reset");
    @(posedge SysClk); #1;
    Reset_N = 1'b1;

    // lock latency counts valid words only; idle cycles report no byte errors
    for (int n = 1; n <= 18; n++) begin
      nextBits(b); RxDValid = 1'b1; RxData = toWord(b);
      @(posedge SysClk); #1;
      check($sformatf("toggle%0d locked", n), 64'(Locked), 64'(n == 18));
      RxDValid = 1'b0; RxData = 64'h0;
      @(posedge SysClk); #1;
      check($sformatf("toggle%0d idle byteErr", n), 64'(ByteErr), 64'd0);
      check($sformatf("toggle%0d idle locked", n), 64'(Locked), 64'(n == 18));
    end

    Reset_N = 1'b0;
    @(posedge SysClk); #1;
    Reset_N = 1'b1;

    anomalies = 0;
    for (int i = 0; i < 10000; i++) begin
      RxDValid = 1'b1; RxData = {$urandom, $urandom};
      @(posedge SysClk); #1;
      if (Locked || LockedS || BitErr != 8'h00) anomalies++;
    end
    RxDValid = 1'b0;
    check("random lock/bitErr events", 64'(anomalies), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
